qam_mapper: RTL and testbench
=============================

Name: qam_mapper

Overview:
- Stage directly downstream of the byte source generator in the OFDM transmit chain.
- Accepts 8-bit bytes over a valid/ready handshake and splits each byte MSB-first into 1, 2 or 4-bit groups.
- Maps each group Gray-coded onto BPSK/QPSK/16-QAM I/Q constellation points.
- Emits one complex symbol per output handshake, with an end-of-OFDM-symbol marker every NSC symbols, for the IFFT loader.

Parameters:
- W, 16, signed width of out_i/out_q (Q1.15 scaling)
- NSC, 48, data subcarriers per OFDM symbol; out_last period
- AMP_BPSK, 32767, BPSK level (±)
- AMP_QPSK, 23170, QPSK level per rail (±)
- UNIT_QAM16, 10362, 16-QAM unit level; rail values are ±1·U and ±3·U

Ports:
- aclk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- mod  in  2  modulation: 00 BPSK, 01 QPSK, 10 16-QAM, 11 treated as QPSK
- in_data  in  8  byte from source
- in_valid  in  1  in_data valid
- in_ready  out  1  mapper accepts a byte this cycle; drives the source's ready
- out_i  out  W  in-phase sample, two's complement
- out_q  out  W  quadrature sample, two's complement
- out_valid  out  1  out_i/out_q/out_last valid
- out_ready  in  1  downstream accepts
- out_last  out  1  last symbol of an NSC-symbol group

Behaviour:
- Reset (sync, on aclk edge with reset=1):
  - out_valid=0, out_i=0, out_q=0, out_last=0.
  - Byte buffer and remaining-group count rem cleared to 0.
  - Latched mode = QPSK; subcarrier counter sc=0.
  - Any partial byte is discarded.
  - in_ready is 0 while reset is high.
- Byte buffer: shift register sh[7:0] plus rem (groups left: 8/4/2 for BPSK/QPSK/16QAM).
  - On in_valid & in_ready: sh<=in_data, rem<=groups(mod), mode latched from mod.
  - mod is sampled only at byte acceptance; changing mod mid-byte has no effect until the next byte.
- load = (rem!=0) & (!out_valid | out_ready).
  - On load: output register takes the mapping of the top group of sh, sh shifts left by the group size, and rem decrements.
- in_ready = !reset & ((rem==0) | (rem==1 & load)). This is combinational from out_ready and gives full throughput with no bubble between bytes.
- Latency: byte accepted at edge k; first symbol has out_valid=1 after edge k+1.
- Output hold: while out_valid=1 and out_ready=0, out_i/out_q/out_last are held stable. out_valid drops only when out_ready=1 and no load occurs.
- Mapping (bit 0 = -, bit 1 = +):
  - BPSK: b -> I=±AMP_BPSK, Q=0.
  - QPSK: b1 -> I=±AMP_QPSK, b0 -> Q=±AMP_QPSK.
  - 16-QAM: b3b2 -> I, b1b0 -> Q, Gray coded: 00->-3U, 01->-1U, 11->+1U, 10->+3U.
  - All values are computed at width W; no saturation is needed (3·U < 2^(W-1)).
- Framing:
  - sc increments on every load.
  - out_last=1 is loaded together with the symbol where sc==NSC-1; sc then wraps to 0.
  - sc is not cleared on mode change.
- Simultaneous events:
  - Accepting a new byte in the same cycle the last group of the previous byte loads is legal. The new byte overwrites sh after that shift.
  - reset has priority over all handshakes.

Optional Feature:
- Macro QAM_MAPPER_SYMCNT_EN.
- When defined:
  - Adds output port sym_cnt [31:0]: total output handshakes (out_valid & out_ready) since reset, wrapping at 2^32.
  - Adds output port frame_cnt [15:0]: handshakes with out_last=1, wrapping.
  - Both counters reset to 0.
- When undefined, neither port nor counter logic exists. Data-path behaviour is identical in both builds.

Test Plan:
- QPSK, out_ready=1, byte 0xAA -> four symbols, each I=+23170, Q=-23170; in_ready=0 for 3 cycles, then 1.
- 16-QAM, bytes 0xAA then 0x05, back-to-back -> (31086,31086), (31086,31086), (-31086,-31086), (-10362,-10362) on 4 consecutive cycles, no bubble.
- BPSK, byte 0xAA -> 8 symbols, I alternating +32767/-32767 starting positive, Q=0; in_ready held 0 until the 8th load.
- Backpressure: QPSK 0x1B with out_ready toggled 0/1 every cycle -> outputs are stable while stalled, and the sequence is (-,-),(-,+),(+,-),(+,+) times 23170.
- Framing: NSC=48, QPSK, 24 bytes -> out_last=1 exactly on symbols 48 and 96; with the macro defined, frame_cnt=2 and sym_cnt=96.
- Reset mid-byte: 16-QAM, assert reset after the first symbol of 0xAA -> next cycle out_valid=0 and the second symbol is never emitted; the next byte's first symbol has sc restarted at 0.

Source files
------------

// File: rtl/qam_mapper.sv
// rtl/qam_mapper.sv - Gray-coded BPSK/QPSK/16-QAM byte-to-symbol mapper; QAM_MAPPER_SYMCNT_EN adds handshake counters
module qam_mapper #(
  parameter int W          = 16,
  parameter int NSC        = 48,
  parameter int AMP_BPSK   = 32767,
  parameter int AMP_QPSK   = 23170,
  parameter int UNIT_QAM16 = 10362
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic [1:0]          mod,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
`ifdef QAM_MAPPER_SYMCNT_EN
  ,
  output logic [31:0]         sym_cnt,
  output logic [15:0]         frame_cnt
`endif
);

  localparam int SCW = (NSC > 1) ? $clog2(NSC) : 1;

  localparam logic [1:0] MODE_BPSK  = 2'b00;
  localparam logic [1:0] MODE_QPSK  = 2'b01;
  localparam logic [1:0] MODE_QAM16 = 2'b10;

  localparam logic signed [W-1:0] P_BPSK = W'(AMP_BPSK);
  localparam logic signed [W-1:0] N_BPSK = W'(-AMP_BPSK);
  localparam logic signed [W-1:0] P_QPSK = W'(AMP_QPSK);
  localparam logic signed [W-1:0] N_QPSK = W'(-AMP_QPSK);
  localparam logic signed [W-1:0] P1_QAM = W'(UNIT_QAM16);
  localparam logic signed [W-1:0] N1_QAM = W'(-UNIT_QAM16);
  localparam logic signed [W-1:0] P3_QAM = W'(3 * UNIT_QAM16);
  localparam logic signed [W-1:0] N3_QAM = W'(-3 * UNIT_QAM16);

  logic [7:0]          sh;
  logic [3:0]          rem;
  logic [1:0]          mode;
  logic [SCW-1:0]      sc;
  logic                load;
  logic                accept;
  logic                sc_wrap;
  logic [7:0]          sh_shift;
  logic signed [W-1:0] map_i;
  logic signed [W-1:0] map_q;

  // Groups per byte for the mode presented with a new byte; 11 behaves as QPSK
  function automatic logic [3:0] groups(input logic [1:0] m);
    case (m)
      MODE_BPSK:  return 4'd8;
      MODE_QAM16: return 4'd2;
      default:    return 4'd4;
    endcase
  endfunction

  // Gray-coded 16-QAM rail level for a two-bit field
  function automatic logic signed [W-1:0] qam16_rail(input logic [1:0] b);
    case (b)
      2'b00:   return N3_QAM;
      2'b01:   return N1_QAM;
      2'b11:   return P1_QAM;
      default: return P3_QAM;
    endcase
  endfunction

  assign load     = (rem != 4'd0) && (!out_valid || out_ready);
  assign in_ready = !reset && ((rem == 4'd0) || ((rem == 4'd1) && load));
  assign accept   = in_valid && in_ready;
  assign sc_wrap  = (sc == SCW'(NSC - 1));

  // Map the top group of the byte buffer and compute the buffer after its removal
  always_comb begin
    map_i    = '0;
    map_q    = '0;
    sh_shift = sh;
    case (mode)
      MODE_BPSK: begin
        map_i    = sh[7] ? P_BPSK : N_BPSK;
        map_q    = '0;
        sh_shift = {sh[6:0], 1'b0};
      end
      MODE_QAM16: begin
        map_i    = qam16_rail(sh[7:6]);
        map_q    = qam16_rail(sh[5:4]);
        sh_shift = {sh[3:0], 4'b0000};
      end
      default: begin
        map_i    = sh[7] ? P_QPSK : N_QPSK;
        map_q    = sh[6] ? P_QPSK : N_QPSK;
        sh_shift = {sh[5:0], 2'b00};
      end
    endcase
  end

  // Byte buffer, output register and subcarrier counter; a new byte overwrites the post-shift buffer
  always_ff @(posedge aclk) begin
    if (reset) begin
      sh        <= '0;
      rem       <= '0;
      mode      <= MODE_QPSK;
      sc        <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (load) begin
        out_i     <= map_i;
        out_q     <= map_q;
        out_last  <= sc_wrap;
        out_valid <= 1'b1;
        sh        <= sh_shift;
        rem       <= rem - 4'd1;
        sc        <= sc_wrap ? '0 : sc + SCW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        sh   <= in_data;
        rem  <= groups(mod);
        mode <= mod;
      end
    end
  end

`ifdef QAM_MAPPER_SYMCNT_EN
  // Count completed output handshakes and completed OFDM symbols
  always_ff @(posedge aclk) begin
    if (reset) begin
      sym_cnt   <= '0;
      frame_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sym_cnt <= sym_cnt + 32'd1;
      if (out_last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qam_mapper.sv
// tb/tb_qam_mapper.sv - randomized self-checking bench for qam_mapper against a symbol-list reference model
module tb_qam_mapper;
  localparam int W   = 16;
  localparam int NSC = 48;
  localparam int AB  = 32767;
  localparam int AQ  = 23170;
  localparam int U   = 10362;

  logic                aclk = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          mod = 2'b01;
  logic [7:0]          in_data = 8'h00;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                out_last;
`ifdef QAM_MAPPER_SYMCNT_EN
  logic [31:0]         sym_cnt;
  logic [15:0]         frame_cnt;
`endif

  qam_mapper dut (
    .aclk      (aclk),
    .reset     (reset),
    .mod       (mod),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef QAM_MAPPER_SYMCNT_EN
    ,
    .sym_cnt   (sym_cnt),
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;
  int model_idx = 0;
  bit rnd_done;

  int exp_i[$];
  int exp_q[$];
  bit exp_last[$];
  int got_i[$];
  int got_q[$];
  bit got_last[$];
  int got_cyc[$];

  always @(posedge aclk) cyc <= cyc + 1;

  // Record every completed output handshake
  always @(negedge aclk) begin
    if (!reset && out_valid && out_ready) begin
      got_i.push_back(int'(out_i));
      got_q.push_back(int'(out_q));
      got_last.push_back(out_last);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: split byte MSB-first, Gray-decode to level index, place symbol in the NSC frame
  function automatic int qam_level(input int two_bits);
    int b1, b0, idx;
    b1  = (two_bits >> 1) & 1;
    b0  = two_bits & 1;
    idx = 2 * b1 + (b1 ^ b0);
    return (2 * idx - 3) * U;
  endfunction

  task automatic model_push(input logic [7:0] b, input logic [1:0] m);
    int bits, n, g, vi, vq;
    bits = (m == 2'b00) ? 1 : ((m == 2'b10) ? 4 : 2);
    n = 8 / bits;
    for (int k = 0; k < n; k++) begin
      g = (int'(b) >> (8 - bits * (k + 1))) & ((1 << bits) - 1);
      if (bits == 1) begin
        vi = (g != 0) ? AB : -AB;
        vq = 0;
      end else if (bits == 2) begin
        vi = ((g >> 1) & 1) ? AQ : -AQ;
        vq = (g & 1) ? AQ : -AQ;
      end else begin
        vi = qam_level(g >> 2);
        vq = qam_level(g & 3);
      end
      model_idx++;
      exp_i.push_back(vi);
      exp_q.push_back(vq);
      exp_last.push_back((model_idx % NSC) == 0);
    end
  endtask

  task automatic clear_queues();
    exp_i.delete(); exp_q.delete(); exp_last.delete();
    got_i.delete(); got_q.delete(); got_last.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    reset = 1'b0;
    model_idx = 0;
    clear_queues();
  endtask

  // Offer one byte; returns 1 time unit after the accepting edge
  task automatic send_byte(input logic [7:0] b, input logic [1:0] m, input bit keep);
    int t;
    in_data = b;
    mod = m;
    in_valid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!in_ready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout byte %02h never accepted", b);
      in_valid = 1'b0;
    end else begin
      @(posedge aclk);
      model_push(b, m);
      #1;
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    @(negedge aclk);
    while ((got_i.size() < exp_i.size() || out_valid) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    n_checks++;
    if (t >= 2000) $display("FAIL drain_timeout got %0d symbols want %0d", got_i.size(), exp_i.size());
    else n_pass++;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (int'(out_i) !== 0) $display("FAIL reset_out_i got %0d want 0", out_i); else n_pass++;
    n_checks++; if (int'(out_q) !== 0) $display("FAIL reset_out_q got %0d want 0", out_q); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    in_valid = 1'b0;
    reset = 1'b0;
    model_idx = 0;
    clear_queues();
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_qpsk();
    out_ready = 1'b1;
    send_byte(8'hAA, 2'b01, 1'b0);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (in_ready !== (c == 3)) $display("FAIL qpsk_in_ready cycle %0d got %b want %b", c, in_ready, (c == 3));
      else n_pass++;
      @(posedge aclk);
      #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL qpsk_valid sym %0d got %b want 1", c, out_valid); else n_pass++;
      n_checks++; if (int'(out_i) !== AQ) $display("FAIL qpsk_i sym %0d got %0d want %0d", c, out_i, AQ); else n_pass++;
      n_checks++; if (int'(out_q) !== -AQ) $display("FAIL qpsk_q sym %0d got %0d want %0d", c, out_q, -AQ); else n_pass++;
    end
    @(posedge aclk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL qpsk_idle_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_qam16_back_to_back();
    int e[4];
    e[0] = 3 * U; e[1] = 3 * U; e[2] = -3 * U; e[3] = -U;
    out_ready = 1'b1;
    clear_queues();
    send_byte(8'hAA, 2'b10, 1'b1);
    send_byte(8'h05, 2'b10, 1'b0);
    wait_drain();
    n_checks++; if (got_i.size() !== 4) $display("FAIL qam16_count got %0d want 4", got_i.size()); else n_pass++;
    for (int k = 0; k < 4 && k < got_i.size(); k++) begin
      n_checks++; if (got_i[k] !== e[k]) $display("FAIL qam16_i sym %0d got %0d want %0d", k, got_i[k], e[k]); else n_pass++;
      n_checks++; if (got_q[k] !== e[k]) $display("FAIL qam16_q sym %0d got %0d want %0d", k, got_q[k], e[k]); else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (got_cyc[k] !== got_cyc[k-1] + 1) $display("FAIL qam16_bubble sym %0d at cycle %0d want %0d", k, got_cyc[k], got_cyc[k-1] + 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bpsk();
    int e;
    out_ready = 1'b1;
    send_byte(8'hAA, 2'b00, 1'b0);
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (in_ready !== (c == 7)) $display("FAIL bpsk_in_ready cycle %0d got %b want %b", c, in_ready, (c == 7));
      else n_pass++;
      @(posedge aclk);
      #1;
      e = (c % 2 == 0) ? AB : -AB;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bpsk_valid sym %0d got %b want 1", c, out_valid); else n_pass++;
      n_checks++; if (int'(out_i) !== e) $display("FAIL bpsk_i sym %0d got %0d want %0d", c, out_i, e); else n_pass++;
      n_checks++; if (int'(out_q) !== 0) $display("FAIL bpsk_q sym %0d got %0d want 0", c, out_q); else n_pass++;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_backpressure();
    int ei[4];
    int eq[4];
    ei[0] = -AQ; eq[0] = -AQ;
    ei[1] = -AQ; eq[1] =  AQ;
    ei[2] =  AQ; eq[2] = -AQ;
    ei[3] =  AQ; eq[3] =  AQ;
    clear_queues();
    out_ready = 1'b0;
    fork
      send_byte(8'h1B, 2'b01, 1'b0);
      begin
        for (int c = 0; c < 24; c++) begin
          @(posedge aclk);
          #1;
          out_ready = ~out_ready;
        end
        out_ready = 1'b1;
      end
      begin
        bit stalled;
        int pi, pq;
        bit pl;
        stalled = 1'b0;
        for (int c = 0; c < 24; c++) begin
          @(negedge aclk);
          if (stalled) begin
            n_checks++;
            if (out_valid !== 1'b1 || int'(out_i) !== pi || int'(out_q) !== pq || out_last !== pl)
              $display("FAIL bp_hold cycle %0d got v=%b i=%0d q=%0d want v=1 i=%0d q=%0d", c, out_valid, out_i, out_q, pi, pq);
            else n_pass++;
          end
          stalled = out_valid && !out_ready;
          pi = int'(out_i);
          pq = int'(out_q);
          pl = out_last;
        end
      end
    join
    wait_drain();
    n_checks++; if (got_i.size() !== 4) $display("FAIL bp_count got %0d want 4", got_i.size()); else n_pass++;
    for (int k = 0; k < 4 && k < got_i.size(); k++) begin
      n_checks++;
      if (got_i[k] !== ei[k] || got_q[k] !== eq[k])
        $display("FAIL bp_sym %0d got (%0d,%0d) want (%0d,%0d)", k, got_i[k], got_q[k], ei[k], eq[k]);
      else n_pass++;
    end
  endtask

  task automatic test_framing();
    int nl;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) send_byte(8'($urandom), 2'b01, k != 23);
    wait_drain();
    n_checks++; if (got_i.size() !== 96) $display("FAIL frame_count got %0d want 96", got_i.size()); else n_pass++;
    nl = 0;
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      if (got_last[k]) nl++;
      n_checks++;
      if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_last[k] !== exp_last[k])
        $display("FAIL frame_sym %0d got (%0d,%0d,%b) want (%0d,%0d,%b)", k, got_i[k], got_q[k], got_last[k], exp_i[k], exp_q[k], exp_last[k]);
      else n_pass++;
    end
    n_checks++; if (nl !== 2) $display("FAIL frame_last_total got %0d want 2", nl); else n_pass++;
`ifdef QAM_MAPPER_SYMCNT_EN
    n_checks++; if (sym_cnt !== 32'd96) $display("FAIL sym_cnt got %0d want 96", sym_cnt); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd2) $display("FAIL frame_cnt got %0d want 2", frame_cnt); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_byte();
    out_ready = 1'b1;
    clear_queues();
    send_byte(8'hAA, 2'b10, 1'b0);
    @(posedge aclk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || int'(out_i) !== 3 * U) $display("FAIL midrst_first got v=%b i=%0d want v=1 i=%0d", out_valid, out_i, 3 * U);
    else n_pass++;
    reset = 1'b1;
    @(posedge aclk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else n_pass++;
    reset = 1'b0;
    model_idx = 0;
    clear_queues();
    repeat (3) @(posedge aclk);
    #1;
    n_checks++; if (got_i.size() !== 0) $display("FAIL midrst_leftover got %0d symbols want 0", got_i.size()); else n_pass++;
    for (int k = 0; k < 12; k++) send_byte(8'($urandom), 2'b01, k != 11);
    wait_drain();
    n_checks++; if (got_i.size() !== 48) $display("FAIL midrst_count got %0d want 48", got_i.size()); else n_pass++;
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      n_checks++;
      if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_last[k] !== exp_last[k])
        $display("FAIL midrst_sym %0d got (%0d,%0d,%b) want (%0d,%0d,%b)", k, got_i[k], got_q[k], got_last[k], exp_i[k], exp_q[k], exp_last[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    clear_queues();
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          send_byte(8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
          if (!in_valid) begin
            mod = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge aclk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    n_checks++;
    if (got_i.size() !== exp_i.size()) $display("FAIL rnd_count got %0d want %0d", got_i.size(), exp_i.size());
    else n_pass++;
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      n_checks++;
      if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_last[k] !== exp_last[k])
        $display("FAIL rnd_sym %0d got (%0d,%0d,%b) want (%0d,%0d,%b)", k, got_i[k], got_q[k], got_last[k], exp_i[k], exp_q[k], exp_last[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_qam16_back_to_back();
    test_bpsk();
    test_backpressure();
    test_framing();
    test_reset_mid_byte();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
